gcd_unit_param: RTL and testbench

Self-contained, width-parametrised GCD unit. It integrates the A/B datapath registers, the comparator/subtractor and the IDLE/CALC/DONE controller behind val/rdy handshakes on both sides. Beyond the fixed-width control block it replaces, it adds:
- a saturating iteration count per result
- an error flag for the both-zero operand case
- back-to-back operation: new operands are accepted in the same cycle the result is consumed.

It sits between an operand producer and a result consumer in the GCD test harness.

---
 rtl/gcd_unit_param_if.sv | 42 ++++
 rtl/gcd_unit_param.sv | 118 +++++++++++
 tb/tb_gcd_unit_param.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_unit_param_if.sv
// Handshake bundle for gcd_unit_param.
// Operand channel: operands_val/operands_rdy with operands_bits_A/B.
// Result channel : result_val/result_rdy with result_bits_data, result_iters, result_err.
// master = producer/consumer side, slave = the GCD unit.
interface gcd_unit_param_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
);
  logic             operands_val;
  logic             operands_rdy;
  logic [W-1:0]     operands_bits_A;
  logic [W-1:0]     operands_bits_B;
  logic             result_val;
  logic             result_rdy;
  logic [W-1:0]     result_bits_data;
  logic [CNT_W-1:0] result_iters;
  logic             result_err;

  modport master (
    output operands_val,
    output operands_bits_A,
    output operands_bits_B,
    output result_rdy,
    input  operands_rdy,
    input  result_val,
    input  result_bits_data,
    input  result_iters,
    input  result_err
  );

  modport slave (
    input  operands_val,
    input  operands_bits_A,
    input  operands_bits_B,
    input  result_rdy,
    output operands_rdy,
    output result_val,
    output result_bits_data,
    output result_iters,
    output result_err
  );
endinterface

// File: rtl/gcd_unit_param.sv
// Width-parametrised subtractive GCD unit with val/rdy handshakes.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   io    - gcd_unit_param_if.slave: operand channel in, result channel out,
//           plus a saturating step count and a both-operands-zero error flag.
// A result can be consumed and new operands captured on the same edge.
module gcd_unit_param #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  gcd_unit_param_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ITERS_MAX = '1;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [CNT_W-1:0] iters_q, iters_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iters_inc;
  logic             capture;

  // Saturating step counter increment.
  assign iters_inc = (iters_q == ITERS_MAX) ? iters_q : iters_q + CNT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      iters_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      iters_q <= iters_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath step and output decode.
  always_comb begin
    state_d             = state_q;
    a_d                 = a_q;
    b_d                 = b_q;
    iters_d             = iters_q;
    err_d               = err_q;
    capture             = 1'b0;
    io.operands_rdy     = 1'b0;
    io.result_val       = 1'b0;
    io.result_bits_data = '0;
    io.result_iters     = '0;
    io.result_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        io.operands_rdy = 1'b1;
        capture         = io.operands_val;
      end

      S_CALC: begin
        if (a_q < b_q) begin
          a_d     = b_q;
          b_d     = a_q;
          iters_d = iters_inc;
        end else if (b_q != '0) begin
          // a_q >= b_q here, so the subtraction cannot underflow.
          a_d     = a_q - b_q;
          iters_d = iters_inc;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        io.result_val       = 1'b1;
        io.result_bits_data = a_q;
        io.result_iters     = iters_q;
        io.result_err       = err_q;
        // Operand acceptance is tied to the result leaving, enabling back-to-back.
        io.operands_rdy     = io.result_rdy;
        if (io.result_rdy) begin
          if (io.operands_val) begin
            capture = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Operand capture is identical from IDLE and from DONE.
    if (capture) begin
      a_d     = io.operands_bits_A;
      b_d     = io.operands_bits_B;
      iters_d = '0;
      err_d   = (io.operands_bits_A == '0) && (io.operands_bits_B == '0);
      state_d = S_CALC;
    end
  end

endmodule

// File: tb/tb_gcd_unit_param.sv
// Self-checking bench for gcd_unit_param: directed cases, back-to-back,
// reset mid-computation, counter saturation (CNT_W=2 instance) and
// randomized operands against an arithmetic reference model.
module tb_gcd_unit_param;

  localparam int unsigned W       = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCNT_W  = 2;
  localparam int          TIMEOUT = 5000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gcd_unit_param_if #(.W(W), .CNT_W(CNT_W))  io  ();
  gcd_unit_param_if #(.W(W), .CNT_W(SCNT_W)) ios ();

  gcd_unit_param #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  gcd_unit_param #(.W(W), .CNT_W(SCNT_W)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .io    (ios)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: GCD by Euclid's remainder method; step count from the
  // swap/subtract rule; error when both operands are zero.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned steps,
                                output bit err);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    g = x;
    x = a; y = b; steps = 0;
    while (y != 0) begin
      if (x < y) begin t = x; x = y; y = t; end
      else x = x - y;
      steps++;
    end
    err = (a == 0) && (b == 0);
  endfunction

  // Present operands now, let one edge pass, then withdraw and scramble inputs.
  task automatic send_ops(input int unsigned a, input int unsigned b);
    io.operands_val    = 1'b1;
    io.operands_bits_A = W'(a);
    io.operands_bits_B = W'(b);
    @(posedge clk); #1;
    io.operands_val    = 1'b0;
    io.operands_bits_A = W'($urandom);
    io.operands_bits_B = W'($urandom);
  endtask

  // Count edges after the capture edge until result_val is seen.
  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (io.result_val === 1'b1) begin
        cyc = i;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset               = 1'b1;
    io.operands_val     = 1'b0;
    io.operands_bits_A  = '0;
    io.operands_bits_B  = '0;
    io.result_rdy       = 1'b1;
    ios.operands_val    = 1'b0;
    ios.operands_bits_A = '0;
    ios.operands_bits_B = '0;
    ios.result_rdy      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks += 5;
    if (io.operands_rdy !== 1'b1) begin errors++; $display("FAIL reset_operands_rdy: got %b expected 1", io.operands_rdy); end
    if (io.result_val !== 1'b0) begin errors++; $display("FAIL reset_result_val: got %b expected 0", io.result_val); end
    if (io.result_bits_data !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", io.result_bits_data); end
    if (io.result_iters !== '0) begin errors++; $display("FAIL reset_iters: got %0d expected 0", io.result_iters); end
    if (io.result_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", io.result_err); end
  endtask

  task automatic test_reset_mid_calc();
    int cyc; bit to;
    send_ops(27, 15);               // now in 1st CALC cycle
    @(posedge clk); #1;             // 2nd
    @(posedge clk); #1;             // 3rd
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks += 5;
    if (io.operands_rdy !== 1'b1) begin errors++; $display("FAIL midcalc_reset_rdy: got %b expected 1", io.operands_rdy); end
    if (io.result_val !== 1'b0) begin errors++; $display("FAIL midcalc_reset_val: got %b expected 0", io.result_val); end
    if (io.result_bits_data !== '0) begin errors++; $display("FAIL midcalc_reset_data: got %0d expected 0", io.result_bits_data); end
    if (io.result_iters !== '0) begin errors++; $display("FAIL midcalc_reset_iters: got %0d expected 0", io.result_iters); end
    if (io.result_err !== 1'b0) begin errors++; $display("FAIL midcalc_reset_err: got %b expected 0", io.result_err); end
    send_ops(8, 12);
    wait_done(cyc, to);
    checks += 1;
    if (to) begin errors++; $display("FAIL after_reset_timeout: got no result expected result"); end
    else if (io.result_bits_data !== W'(4)) begin errors++; $display("FAIL after_reset_data: got %0d expected 4", io.result_bits_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int unsigned ta[5], tb_[5], td[5], ti[5], tl[5];
    bit te[5];
    int cyc; bit to;
    ta  = '{15,  5, 0, 9, 0};
    tb_ = '{ 5, 15, 7, 0, 0};
    td  = '{ 5,  5, 7, 9, 0};
    ti  = '{ 4,  5, 1, 0, 0};
    tl  = '{ 5,  6, 2, 1, 1};
    te  = '{ 0,  0, 0, 0, 1};
    for (int k = 0; k < 5; k++) begin
      send_ops(ta[k], tb_[k]);
      wait_done(cyc, to);
      checks += 1;
      if (to) begin
        errors++; $display("FAIL dir%0d_timeout: got no result expected result", k);
      end else begin
        checks += 4;
        if (cyc != int'(tl[k])) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, cyc, tl[k]); end
        if (io.result_bits_data !== W'(td[k])) begin errors++; $display("FAIL dir%0d_data: got %0d expected %0d", k, io.result_bits_data, td[k]); end
        if (io.result_iters !== CNT_W'(ti[k])) begin errors++; $display("FAIL dir%0d_iters: got %0d expected %0d", k, io.result_iters, ti[k]); end
        if (io.result_err !== te[k]) begin errors++; $display("FAIL dir%0d_err: got %b expected %b", k, io.result_err, te[k]); end
      end
      @(posedge clk); #1;
      checks += 2;
      if (io.result_val !== 1'b0) begin errors++; $display("FAIL dir%0d_idle_val: got %b expected 0", k, io.result_val); end
      if (io.operands_rdy !== 1'b1) begin errors++; $display("FAIL dir%0d_idle_rdy: got %b expected 1", k, io.operands_rdy); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    send_ops(15, 5);
    wait_done(cyc, to);
    checks += 1;
    if (to || io.result_bits_data !== W'(5)) begin errors++; $display("FAIL b2b_first_data: got %0d expected 5", io.result_bits_data); end
    io.operands_val    = 1'b1;
    io.operands_bits_A = W'(21);
    io.operands_bits_B = W'(14);
    #1;
    checks += 1;
    if (io.operands_rdy !== 1'b1) begin errors++; $display("FAIL b2b_operands_rdy: got %b expected 1", io.operands_rdy); end
    @(posedge clk); #1;
    io.operands_val = 1'b0;
    #1;
    checks += 2;
    if (io.result_val !== 1'b0) begin errors++; $display("FAIL b2b_consumed_val: got %b expected 0", io.result_val); end
    if (io.operands_rdy !== 1'b0) begin errors++; $display("FAIL b2b_in_calc_rdy: got %b expected 0", io.operands_rdy); end
    wait_done(cyc, to);
    checks += 4;
    if (to) begin errors++; $display("FAIL b2b_timeout: got no result expected result"); end
    if (cyc != 6) begin errors++; $display("FAIL b2b_latency: got %0d expected 6", cyc); end
    if (io.result_bits_data !== W'(7)) begin errors++; $display("FAIL b2b_data: got %0d expected 7", io.result_bits_data); end
    if (io.result_iters !== CNT_W'(5)) begin errors++; $display("FAIL b2b_iters: got %0d expected 5", io.result_iters); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int cyc;
    ios.operands_val    = 1'b1;
    ios.operands_bits_A = W'(15);
    ios.operands_bits_B = W'(5);
    @(posedge clk); #1;
    ios.operands_val = 1'b0;
    cyc = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk); #1;
      if (ios.result_val === 1'b1) begin cyc = i; break; end
    end
    checks += 1;
    if (cyc != 5) begin errors++; $display("FAIL sat_latency: got %0d expected 5", cyc); end
    for (int i = 0; i < 10; i++) begin
      ios.operands_val    = i[0];
      ios.operands_bits_A = W'($urandom);
      ios.operands_bits_B = W'($urandom);
      #1;
      checks += 5;
      if (ios.result_val !== 1'b1) begin errors++; $display("FAIL sat_hold_val[%0d]: got %b expected 1", i, ios.result_val); end
      if (ios.result_bits_data !== W'(5)) begin errors++; $display("FAIL sat_hold_data[%0d]: got %0d expected 5", i, ios.result_bits_data); end
      if (ios.result_iters !== SCNT_W'(3)) begin errors++; $display("FAIL sat_hold_iters[%0d]: got %0d expected 3", i, ios.result_iters); end
      if (ios.result_err !== 1'b0) begin errors++; $display("FAIL sat_hold_err[%0d]: got %b expected 0", i, ios.result_err); end
      if (ios.operands_rdy !== 1'b0) begin errors++; $display("FAIL sat_hold_rdy[%0d]: got %b expected 0", i, ios.operands_rdy); end
      @(posedge clk); #1;
    end
    ios.operands_val = 1'b0;
    ios.result_rdy   = 1'b1;
    @(posedge clk); #1;
    #1;
    checks += 2;
    if (ios.result_val !== 1'b0) begin errors++; $display("FAIL sat_release_val: got %b expected 0", ios.result_val); end
    if (ios.operands_rdy !== 1'b1) begin errors++; $display("FAIL sat_release_rdy: got %b expected 1", ios.operands_rdy); end
  endtask

  task automatic test_random();
    int unsigned a, b, g, steps, exp_it, h;
    bit err;
    int cyc; bit to;
    logic [W-1:0] held;
    a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
    b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
    send_ops(a, b);
    for (int k = 0; k < 40; k++) begin
      model(a, b, g, steps, err);
      exp_it = (steps > 255) ? 255 : steps;
      wait_done(cyc, to);
      checks += 1;
      if (to) begin
        errors++; $display("FAIL rnd%0d_timeout: A=%0d B=%0d got no result", k, a, b);
      end else begin
        checks += 4;
        if (cyc != int'(steps + 1)) begin errors++; $display("FAIL rnd%0d_latency: A=%0d B=%0d got %0d expected %0d", k, a, b, cyc, steps + 1); end
        if (io.result_bits_data !== W'(g)) begin errors++; $display("FAIL rnd%0d_data: A=%0d B=%0d got %0d expected %0d", k, a, b, io.result_bits_data, g); end
        if (io.result_iters !== CNT_W'(exp_it)) begin errors++; $display("FAIL rnd%0d_iters: A=%0d B=%0d got %0d expected %0d", k, a, b, io.result_iters, exp_it); end
        if (io.result_err !== err) begin errors++; $display("FAIL rnd%0d_err: A=%0d B=%0d got %b expected %b", k, a, b, io.result_err, err); end
      end
      h = $urandom_range(0, 2);
      held = io.result_bits_data;
      if (h != 0) begin
        io.result_rdy = 1'b0;
        repeat (h) begin @(posedge clk); #1; end
        checks += 1;
        if (io.result_val !== 1'b1 || io.result_bits_data !== held) begin
          errors++; $display("FAIL rnd%0d_hold: got val=%b data=%0d expected val=1 data=%0d", k, io.result_val, io.result_bits_data, held);
        end
        io.result_rdy = 1'b1;
      end
      if (k == 39) begin
        @(posedge clk); #1;
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
        b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 0) begin
          @(posedge clk); #1;       // drop to IDLE first
        end
        send_ops(a, b);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_calc();
    test_directed();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
